// File: rtl/lp_mc_iir_if.sv
// ============================================================================
// lp_mc_iir_if : sample-in / sample-out valid-ready streams of lp_mc_iir
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lp_mc_iir_if #(
    parameter int DATA_W = 24,
    parameter int N_CH   = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     i_valid;
    logic                     o_ready;
    logic signed [DATA_W-1:0] i_data;
    logic        [CH_W-1:0]   i_ch;
    logic                     o_valid;
    logic                     i_ready;
    logic signed [DATA_W-1:0] o_data;
    logic        [CH_W-1:0]   o_ch;
    logic                     o_drop;

    modport slave (
        input  i_valid, i_data, i_ch, i_ready,
        output o_ready, o_valid, o_data, o_ch, o_drop
    );

    modport master (
        output i_valid, i_data, i_ch, i_ready,
        input  o_ready, o_valid, o_data, o_ch, o_drop
    );
endinterface

`default_nettype wire

// File: rtl/lp_mc_iir.sv
// ============================================================================
// lp_mc_iir : time-multiplexed multi-channel one-pole IIR low-pass filter
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module lp_mc_iir #(
    parameter int DATA_W        = 24,
    parameter int N_CH          = 8,
    parameter int SHIFT_W       = 4,
    parameter int DEFAULT_SHIFT = 3,
    localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  wire logic                i_clk,
    input  wire logic                i_rst_n,
    lp_mc_iir_if.slave               s_io,
    input  wire logic                i_cfg_we,
    input  wire logic [CH_W-1:0]     i_cfg_ch,
    input  wire logic [SHIFT_W-1:0]  i_cfg_shift,
    input  wire logic                i_cfg_bypass,
    input  wire logic                i_clr
);
    localparam logic [CH_W:0] N_CH_EXT = (CH_W + 1)'(N_CH);

    logic signed [DATA_W-1:0] state_q  [N_CH];
    logic        [SHIFT_W-1:0] shift_q [N_CH];
    logic                     bypass_q [N_CH];

    logic                     valid_q, valid_d;
    logic signed [DATA_W-1:0] data_q,  data_d;
    logic        [CH_W-1:0]   ch_q,    ch_d;
    logic                     drop_q,  drop_d;

    logic signed [DATA_W-1:0] w_sel_state;
    logic        [SHIFT_W-1:0] w_sel_shift;
    logic                     w_sel_bypass;
    logic                     w_ready;
    logic                     w_in_range;
    logic                     w_accept;
    logic                     w_take;
    logic                     w_clr_hit;
    logic signed [DATA_W-1:0] w_yprev;
    logic signed [DATA_W:0]   w_diff;
    logic signed [DATA_W:0]   w_step;
    logic signed [DATA_W:0]   w_sum;
    logic signed [DATA_W-1:0] w_y;

    assign w_ready    = !valid_q || s_io.i_ready;
    assign w_in_range = {1'b0, s_io.i_ch} < N_CH_EXT;
    assign w_accept   = s_io.i_valid && w_ready;
    assign w_take     = w_accept && w_in_range;
    assign w_clr_hit  = i_clr && (i_cfg_ch == s_io.i_ch);

    always_comb begin
        w_sel_state  = '0;
        w_sel_shift  = '0;
        w_sel_bypass = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (s_io.i_ch == CH_W'(c)) begin
                w_sel_state  = state_q[c];
                w_sel_shift  = shift_q[c];
                w_sel_bypass = bypass_q[c];
            end
        end
    end

    // The sum always lies between y_prev and x, so dropping the top bit is exact.
    assign w_yprev = w_clr_hit ? '0 : w_sel_state;
    assign w_diff  = {s_io.i_data[DATA_W-1], s_io.i_data} - {w_yprev[DATA_W-1], w_yprev};
    assign w_step  = w_diff >>> w_sel_shift;
    assign w_sum   = {w_yprev[DATA_W-1], w_yprev} + w_step;
    assign w_y     = w_sel_bypass ? s_io.i_data : DATA_W'(w_sum);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        drop_d  = w_accept && !w_in_range;
        if (w_ready) begin
            valid_d = w_take;
        end
        if (w_take) begin
            data_d = w_y;
            ch_d   = s_io.i_ch;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            drop_q  <= drop_d;
        end
    end

    // An accepted sample's result wins over a same-cycle clear of that channel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c]  <= '0;
                shift_q[c]  <= SHIFT_W'(DEFAULT_SHIFT);
                bypass_q[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_take && (s_io.i_ch == CH_W'(c))) begin
                    state_q[c] <= w_y;
                end else if (i_clr && (i_cfg_ch == CH_W'(c))) begin
                    state_q[c] <= '0;
                end
                if (i_cfg_we && (i_cfg_ch == CH_W'(c))) begin
                    shift_q[c]  <= i_cfg_shift;
                    bypass_q[c] <= i_cfg_bypass;
                end
            end
        end
    end

    assign s_io.o_ready = w_ready;
    assign s_io.o_valid = valid_q;
    assign s_io.o_data  = data_q;
    assign s_io.o_ch    = ch_q;
    assign s_io.o_drop  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_lp_mc_iir.sv
// ============================================================================
// tb_lp_mc_iir : self-checking bench for lp_mc_iir (DATA_W=16, N_CH=4 and 3)
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lp_mc_iir;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lp_mc_iir_if #(.DATA_W(16), .N_CH(4)) bus4 ();
    lp_mc_iir_if #(.DATA_W(16), .N_CH(3)) bus3 ();

    logic       cfg_we, cfg_byp, clr;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_shift;

    lp_mc_iir #(.DATA_W(16), .N_CH(4), .SHIFT_W(4), .DEFAULT_SHIFT(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .s_io(bus4),
        .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_shift(cfg_shift),
        .i_cfg_bypass(cfg_byp), .i_clr(clr)
    );

    lp_mc_iir #(.DATA_W(16), .N_CH(3), .SHIFT_W(4), .DEFAULT_SHIFT(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .s_io(bus3),
        .i_cfg_we(1'b0), .i_cfg_ch(2'd0), .i_cfg_shift(4'd0),
        .i_cfg_bypass(1'b0), .i_clr(1'b0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-channel filter state as plain integers.
    int mstate [4];
    int mshift [4];
    bit mbyp   [4];
    bit m_valid;
    int m_data;
    int m_ch;

    typedef struct {
        int ch;
        int x;
        int exp;
    } vec_t;
    vec_t tv [7];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // y = y_prev + floor((x - y_prev) / 2^k)
    function automatic int iir(input int x, input int yp, input int k);
        int d = x - yp;
        int p = 1 << k;
        if (d >= 0) return yp + d / p;
        return yp - ((-d + p - 1) / p);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            mstate[c] = 0;
            mshift[c] = 3;
            mbyp[c]   = 1'b0;
        end
        m_valid = 1'b0;
        m_data  = 0;
        m_ch    = 0;
    endtask

    task automatic tick();
        bit acc;
        int ch, x, yp, y;
        acc = bus4.i_valid && (!m_valid || bus4.i_ready);
        ch  = int'(bus4.i_ch);
        x   = int'(bus4.i_data);
        y   = 0;
        if (acc) begin
            yp = (clr && (cfg_ch == bus4.i_ch)) ? 0 : mstate[ch];
            y  = mbyp[ch] ? x : iir(x, yp, mshift[ch]);
        end
        if (clr) mstate[int'(cfg_ch)] = 0;
        if (acc) begin
            mstate[ch] = y;
            m_data     = y;
            m_ch       = ch;
            m_valid    = 1'b1;
        end else if (!m_valid || bus4.i_ready) begin
            m_valid = 1'b0;
        end
        if (cfg_we) begin
            mshift[int'(cfg_ch)] = int'(cfg_shift);
            mbyp[int'(cfg_ch)]   = cfg_byp;
        end
        @(posedge clk);
        #1;
        chk("o_valid", int'(bus4.o_valid), int'(m_valid));
        chk("o_ready", int'(bus4.o_ready), int'(!m_valid || bus4.i_ready));
        chk("o_drop", int'(bus4.o_drop), 0);
        if (m_valid) begin
            chk("o_data", int'(bus4.o_data), m_data);
            chk("o_ch", int'(bus4.o_ch), m_ch);
        end
    endtask

    task automatic send(input int ch, input int x);
        bus4.i_valid = 1'b1;
        bus4.i_ch    = 2'(ch);
        bus4.i_data  = 16'(x);
        tick();
    endtask

    task automatic idle();
        bus4.i_valid = 1'b0;
        tick();
    endtask

    task automatic cfg(input int ch, input int k, input bit byp, input bit do_clr);
        bus4.i_valid = 1'b0;
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_shift = 4'(k);
        cfg_byp   = byp;
        clr       = do_clr;
        tick();
        cfg_we = 1'b0;
        clr    = 1'b0;
    endtask

    initial begin
        tv[0] = '{0, 1000, 250};
        tv[1] = '{0, 1000, 437};
        tv[2] = '{0, 1000, 577};
        tv[3] = '{0, 1000, 250};
        tv[4] = '{1, -400, -100};
        tv[5] = '{0, 1000, 437};
        tv[6] = '{1, -400, -175};

        rst_n = 1'b0;
        bus4.i_valid = 1'b0; bus4.i_ready = 1'b1; bus4.i_ch = '0; bus4.i_data = '0;
        bus3.i_valid = 1'b0; bus3.i_ready = 1'b1; bus3.i_ch = '0; bus3.i_data = '0;
        cfg_we = 1'b0; cfg_byp = 1'b0; clr = 1'b0; cfg_ch = '0; cfg_shift = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst o_valid", int'(bus4.o_valid), 0);
        chk("rst o_data", int'(bus4.o_data), 0);
        chk("rst o_ch", int'(bus4.o_ch), 0);
        chk("rst o_drop", int'(bus4.o_drop), 0);
        chk("rst o_ready", int'(bus4.o_ready), 1);
        #2 rst_n = 1'b1;

        // Out-of-range channel on the 3-channel instance
        bus3.i_valid = 1'b1; bus3.i_ch = 2'd0; bus3.i_data = 16'sd1000;
        tick();
        chk("n3 valid", int'(bus3.o_valid), 1);
        chk("n3 data", int'(bus3.o_data), 125);
        chk("n3 drop", int'(bus3.o_drop), 0);
        bus3.i_ch = 2'd3; bus3.i_data = -16'sd30000;
        tick();
        chk("n3 oor valid", int'(bus3.o_valid), 0);
        chk("n3 oor drop", int'(bus3.o_drop), 1);
        bus3.i_ch = 2'd0; bus3.i_data = 16'sd1000;
        tick();
        chk("n3 after valid", int'(bus3.o_valid), 1);
        chk("n3 after data", int'(bus3.o_data), 234);
        chk("n3 after drop", int'(bus3.o_drop), 0);
        bus3.i_valid = 1'b0;
        tick();
        chk("n3 idle valid", int'(bus3.o_valid), 0);
        chk("n3 idle drop", int'(bus3.o_drop), 0);

        // Step response and interleaved channels
        cfg(0, 2, 1'b0, 1'b0);
        cfg(1, 2, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) cfg(0, 2, 1'b0, 1'b1);
            send(tv[i].ch, tv[i].x);
            chk($sformatf("tbl%0d data", i), int'(bus4.o_data), tv[i].exp);
            chk($sformatf("tbl%0d ch", i), int'(bus4.o_ch), tv[i].ch);
        end
        idle();

        // Backpressure on ch2 (default k=3)
        send(2, 800);
        chk("bp first", int'(bus4.o_data), 100);
        bus4.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp hold data", int'(bus4.o_data), 100);
            chk("bp hold ready", int'(bus4.o_ready), 0);
        end
        bus4.i_ready = 1'b1;
        tick();
        chk("bp release", int'(bus4.o_data), 187);
        idle();
        chk("bp no dup", int'(bus4.o_valid), 0);

        // Signed edges on ch3
        cfg(3, 1, 1'b0, 1'b1);
        send(3, -5);
        chk("edge -5 k1", int'(bus4.o_data), -3);
        cfg(3, 0, 1'b0, 1'b0);
        send(3, -32768);
        chk("edge min k0", int'(bus4.o_data), -32768);
        cfg(3, 15, 1'b0, 1'b1);
        send(3, 32767);
        chk("edge max k15", int'(bus4.o_data), 0);
        idle();

        // Bypass, same-cycle clear and same-cycle config on ch2
        cfg(2, 2, 1'b1, 1'b0);
        send(2, 800);
        chk("bypass", int'(bus4.o_data), 800);
        cfg(2, 2, 1'b0, 1'b0);
        clr = 1'b1; cfg_ch = 2'd2;
        send(2, 400);
        chk("clr+acc", int'(bus4.o_data), 100);
        clr = 1'b0;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_shift = 4'd0; cfg_byp = 1'b0;
        send(2, 400);
        chk("cfg old k", int'(bus4.o_data), 175);
        cfg_we = 1'b0;
        send(2, 400);
        chk("cfg new k", int'(bus4.o_data), 400);
        idle();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            bus4.i_valid = ($urandom_range(0, 3) != 0);
            bus4.i_ready = ($urandom_range(0, 3) != 0);
            bus4.i_ch    = 2'($urandom_range(0, 3));
            bus4.i_data  = r;
            cfg_we    = ($urandom_range(0, 15) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_shift = 4'($urandom_range(0, 15));
            cfg_byp   = ($urandom_range(0, 7) == 0);
            clr       = ($urandom_range(0, 15) == 0);
            tick();
        end
        cfg_we = 1'b0; clr = 1'b0; bus4.i_ready = 1'b1;
        idle();

        // Reset in the middle of a stream
        send(0, 800);
        bus4.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst o_valid", int'(bus4.o_valid), 0);
        chk("mid-rst o_data", int'(bus4.o_data), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 800);
        chk("post-rst ch0", int'(bus4.o_data), 100);
        send(2, -800);
        chk("post-rst ch2", int'(bus4.o_data), -100);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
